// File: rtl/step_sequencer_if.sv
// Control bus between the microcode controller and step_sequencer.
// The instr_count signal exists only when STEP_SEQ_INSTR_COUNT_EN is defined.
interface step_sequencer_if;
   logic        run;
   logic        halt;
   logic        step_req;
   logic        step_clr;
   logic        hold;
   logic [2:0]  step;
   logic [2:0]  dec_en;
   logic        instr_start;
   logic        halted;
`ifdef STEP_SEQ_INSTR_COUNT_EN
   logic [15:0] instr_count;

   modport master (
      output run, halt, step_req, step_clr, hold,
      input  step, dec_en, instr_start, halted, instr_count
   );

   modport slave (
      input  run, halt, step_req, step_clr, hold,
      output step, dec_en, instr_start, halted, instr_count
   );
`else
   modport master (
      output run, halt, step_req, step_clr, hold,
      input  step, dec_en, instr_start, halted
   );

   modport slave (
      input  run, halt, step_req, step_clr, hold,
      output step, dec_en, instr_start, halted
   );
`endif
endinterface

// File: rtl/step_sequencer.sv
// Microcode step sequencer driving the select/enable pins of an SN74138 step decoder.
// Optional instruction counter enabled by defining STEP_SEQ_INSTR_COUNT_EN.
module step_sequencer #(
   parameter int MAX_STEP = 7
) (
   input logic             clk,
   input logic             rst_b,
   step_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      SSTEP = 2'd3
   } state_t;

   localparam logic [2:0] LAST_STEP = 3'(MAX_STEP);

   state_t     state_q;
   state_t     state_d;
   logic [2:0] step_q;
   logic [2:0] step_d;
   logic       instr_start_q;
   logic       instr_start_d;
   logic [2:0] dec_en_q;
   logic       halted_q;
   logic       req_q;
   logic       req_edge_q;
   logic       at_boundary;

   // The step_req edge is registered, so SSTEP starts one cycle after the edge is seen.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         req_q      <= 1'b0;
         req_edge_q <= 1'b0;
      end else begin
         req_q      <= bus.step_req;
         req_edge_q <= bus.step_req & ~req_q;
      end
   end

   always_comb begin
      state_d       = state_q;
      step_d        = step_q;
      instr_start_d = 1'b0;
      at_boundary   = (step_q == LAST_STEP) || bus.step_clr;
      if (!bus.hold) begin
         case (state_q)
            IDLE: begin
               if (bus.run) begin
                  state_d       = RUN;
                  instr_start_d = 1'b1;
               end
            end
            RUN: begin
               if (at_boundary) begin
                  step_d = 3'd0;
                  if (bus.halt) begin
                     state_d = HALT;
                  end else if (!bus.run) begin
                     state_d = IDLE;
                  end else begin
                     instr_start_d = 1'b1;
                  end
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
            HALT: begin
               if (req_edge_q) begin
                  state_d       = SSTEP;
                  instr_start_d = 1'b1;
               end else if (!bus.halt && bus.run) begin
                  state_d       = RUN;
                  instr_start_d = 1'b1;
               end
            end
            SSTEP: begin
               if (at_boundary) begin
                  step_d  = 3'd0;
                  state_d = HALT;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
            default: begin
               state_d = IDLE;
               step_d  = 3'd0;
            end
         endcase
      end
   end

   // Decoder enables are flopped from the next state so they never glitch into the ROM strobes.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q       <= IDLE;
         step_q        <= 3'd0;
         instr_start_q <= 1'b0;
         dec_en_q      <= 3'b000;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         instr_start_q <= instr_start_d;
         dec_en_q      <= ((state_d == RUN) || (state_d == SSTEP)) ? 3'b100 : 3'b000;
         halted_q      <= (state_d == HALT);
      end
   end

`ifdef STEP_SEQ_INSTR_COUNT_EN
   logic [15:0] instr_count_q;

   // instr_start_d is never set during hold, so the count freezes with the step.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         instr_count_q <= 16'd0;
      end else if (instr_start_d) begin
         instr_count_q <= instr_count_q + 16'd1;
      end
   end

   assign bus.instr_count = instr_count_q;
`endif

   assign bus.step        = step_q;
   assign bus.dec_en      = dec_en_q;
   assign bus.instr_start = instr_start_q;
   assign bus.halted      = halted_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: directed scenarios then random traffic,
// each cycle checked against a behavioural model of the sequencer rules.
module tb_step_sequencer;

   localparam int MAX_STEP = 7;
   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_HALT   = 2;
   localparam int M_SSTEP  = 3;

   logic clk   = 1'b0;
   logic rst_b = 1'b1;

   always #5 clk = ~clk;

   step_sequencer_if bus ();

   step_sequencer #(.MAX_STEP(MAX_STEP)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   typedef struct packed {
      logic [2:0]  step;
      logic [2:0]  dec_en;
      logic        instr_start;
      logic        halted;
      logic [15:0] count;
   } expect_t;

   expect_t exp_q[$];
   int      vectors     = 0;
   int      miscompares = 0;

   int          m_mode;
   int          m_step;
   bit          m_start;
   logic [15:0] m_count;
   bit          m_req_prev;
   bit          m_edge;

   task automatic modelReset();
      m_mode     = M_IDLE;
      m_step     = 0;
      m_start    = 1'b0;
      m_count    = 16'd0;
      m_req_prev = 1'b0;
      m_edge     = 1'b0;
   endtask

   function automatic bit modelActive();
      return (m_mode == M_RUN) || (m_mode == M_SSTEP);
   endfunction

   function automatic expect_t modelOutputs();
      expect_t e;
      e.step        = 3'(m_step);
      e.dec_en      = modelActive() ? 3'b100 : 3'b000;
      e.instr_start = m_start;
      e.halted      = (m_mode == M_HALT);
`ifdef STEP_SEQ_INSTR_COUNT_EN
      e.count       = m_count;
`else
      e.count       = 16'd0;
`endif
      return e;
   endfunction

   // One clock edge of the sequencer rules, applied to the sampled inputs.
   function automatic void modelAdvance(input bit run, input bit halt, input bit req,
                                        input bit clr, input bit hold);
      bit edge_now;
      bit finishing;
      edge_now   = req && !m_req_prev;
      m_req_prev = req;
      m_start    = 1'b0;
      if (!hold) begin
         finishing = (m_step == MAX_STEP) || clr;
         if (m_mode == M_IDLE) begin
            if (run) begin
               m_mode  = M_RUN;
               m_start = 1'b1;
            end
         end else if (m_mode == M_HALT) begin
            if (m_edge) begin
               m_mode  = M_SSTEP;
               m_start = 1'b1;
            end else if (!halt && run) begin
               m_mode  = M_RUN;
               m_start = 1'b1;
            end
         end else if (finishing) begin
            m_step = 0;
            if (m_mode == M_SSTEP)  m_mode = M_HALT;
            else if (halt)          m_mode = M_HALT;
            else if (!run)          m_mode = M_IDLE;
            else                    m_start = 1'b1;
         end else begin
            m_step = m_step + 1;
         end
         if (m_start) m_count = m_count + 16'd1;
      end
      m_edge = edge_now;
   endfunction

   task automatic checkOutput(input expect_t exp, input string name);
      expect_t act;
      act.step        = bus.step;
      act.dec_en      = bus.dec_en;
      act.instr_start = bus.instr_start;
      act.halted      = bus.halted;
`ifdef STEP_SEQ_INSTR_COUNT_EN
      act.count       = bus.instr_count;
`else
      act.count       = 16'd0;
`endif
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s @%0t: got step=%0d dec_en=%b start=%b halted=%b count=%0d, expected step=%0d dec_en=%b start=%b halted=%b count=%0d",
                  name, $time, act.step, act.dec_en, act.instr_start, act.halted, act.count,
                  exp.step, exp.dec_en, exp.instr_start, exp.halted, exp.count);
      end
   endtask

   task automatic applyStimulus(input bit run, input bit halt, input bit req,
                                input bit clr, input bit hold);
      @(negedge clk);
      bus.run      = run;
      bus.halt     = halt;
      bus.step_req = req;
      bus.step_clr = clr;
      bus.hold     = hold;
      modelAdvance(run, halt, req, clr, hold);
      exp_q.push_back(modelOutputs());
   endtask

   task automatic runUntilStep(input int target, input bit run, input bit halt, input string name);
      int guard;
      guard = 0;
      while (!(modelActive() && m_step == target)) begin
         if (guard == 40) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: step %0d not reached, mode=%0d step=%0d", name, target, m_mode, m_step);
            return;
         end
         applyStimulus(run, halt, 1'b0, 1'b0, 1'b0);
         guard++;
      end
   endtask

   task automatic runUntilHalted(input bit run, input string name);
      int guard;
      guard = 0;
      while (m_mode != M_HALT) begin
         if (guard == 40) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: HALT not reached, mode=%0d", name, m_mode);
            return;
         end
         applyStimulus(run, 1'b1, 1'b0, 1'b0, 1'b0);
         guard++;
      end
   endtask

   // Monitor: every pushed expectation is compared just after the edge it belongs to.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), "cycle");
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit rq;
      bit hold_r;
      bus.run      = 1'b0;
      bus.halt     = 1'b0;
      bus.step_req = 1'b0;
      bus.step_clr = 1'b0;
      bus.hold     = 1'b0;
      modelReset();
      #1 rst_b = 1'b0;
      #1 checkOutput(modelOutputs(), "power_on_reset");
      @(negedge clk);
      rst_b = 1'b1;

      $display("[TB] free run");
      repeat (17) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] early end and hold");
      runUntilStep(3, 1'b1, 1'b0, "reach_step3");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      runUntilStep(2, 1'b1, 1'b0, "reach_step2");
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] halt at boundary");
      runUntilStep(4, 1'b1, 1'b0, "reach_step4");
      runUntilHalted(1'b1, "halt_run");
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] single step with step_req held");
      repeat (13) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] priority checks");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      runUntilStep(5, 1'b1, 1'b0, "reach_step5");
      runUntilHalted(1'b0, "halt_over_idle");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] async reset mid instruction");
      runUntilStep(5, 1'b1, 1'b0, "reach_step5_reset");
      @(posedge clk);
      #3;
      rst_b        = 1'b0;
      bus.run      = 1'b0;
      bus.halt     = 1'b0;
      bus.step_req = 1'b0;
      bus.step_clr = 1'b0;
      bus.hold     = 1'b0;
      modelReset();
      #1 checkOutput(modelOutputs(), "async_reset");
      @(negedge clk);
      rst_b = 1'b1;
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] random traffic");
      rq = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(3) == 0) rq = ~rq;
         hold_r = modelActive() && ($urandom_range(5) == 0);
         applyStimulus($urandom_range(9) < 8, $urandom_range(9) < 2, rq,
                       $urandom_range(7) == 0, hold_r);
      end

      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain: %0d expectations left unchecked", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
